// File: rtl/move_collector.sv
// -----------------------------------------------------------------------------
// move_collector
//
// Consumer side of a square's move-register interface. On a start pulse it
// snapshots the 16 move words of one square (8 sliding directions followed by
// 8 knight directions), skips the empty ones (all-zero words) and streams the
// non-empty words out one per valid/ready handshake, in index order. A one-cycle
// done pulse ends every completed scan, and move_count reports how many moves
// that scan transferred.
//
// Optional feature (compile-time macro MOVE_COLLECT_ABORT_EN):
//   Adds an abort input that returns the block to IDLE from any busy state
//   without a done pulse and without touching move_count.
//
// Ports:
//   clk         rising-edge clock
//   clear_n     synchronous active-low reset
//   start       one-cycle request to collect the current move_bus
//   move_bus    NUM_DIR flattened move words, word i at [i*MOVE_W +: MOVE_W]
//   busy        high whenever the block is not idle
//   move_valid  move_data/move_idx carry a move
//   move_ready  consumer accepts the current move
//   abort       (MOVE_COLLECT_ABORT_EN only) cancel the scan in progress
//   move_data   current move word
//   move_idx    direction index of move_data
//   done        one-cycle pulse when a scan completes
//   move_count  number of moves transferred by the last completed scan
// -----------------------------------------------------------------------------
module move_collector #(
    parameter int NUM_DIR = 16,
    parameter int MOVE_W  = 32,
    parameter int IDX_W   = 4     // 2**IDX_W must be >= NUM_DIR
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      start,
    input  logic [NUM_DIR*MOVE_W-1:0] move_bus,
    output logic                      busy,
    output logic                      move_valid,
    input  logic                      move_ready,
`ifdef MOVE_COLLECT_ABORT_EN
    input  logic                      abort,
`endif
    output logic [MOVE_W-1:0]         move_data,
    output logic [IDX_W-1:0]          move_idx,
    output logic                      done,
    output logic [IDX_W:0]            move_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } state_t;

    state_t                           state;
    state_t                           state_nx;
    logic [NUM_DIR-1:0][MOVE_W-1:0]   snapshot;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W:0]                   cnt;
    logic [MOVE_W-1:0]                cur_word;
    logic                             last_idx;
    logic                             abort_hit;

    assign cur_word = snapshot[idx];
    assign last_idx = (idx == IDX_W'(NUM_DIR - 1));

`ifdef MOVE_COLLECT_ABORT_EN
    // Abort only matters while a scan is in progress; in IDLE a simultaneous
    // start takes effect as usual.
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch forms.
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (cur_word != '0) begin
                    state_nx = EMIT;
                end else if (last_idx) begin
                    state_nx = DONE;
                end
            end
            EMIT: begin
                if (move_ready) begin
                    state_nx = last_idx ? DONE : SCAN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_nx = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot, scan index and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            // NOTE: the snapshot is cleared on reset on purpose: it is only
            // 16 words and a zeroed snapshot keeps move_data at 0 after reset.
            snapshot   <= '0;
            idx        <= '0;
            cnt        <= '0;
            move_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= move_bus;
                        idx      <= '0;
                        cnt      <= '0;
                    end
                end
                SCAN: begin
                    // A non-empty word keeps idx for the EMIT that follows.
                    if ((cur_word == '0) && !last_idx) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                EMIT: begin
                    // A transfer coinciding with abort is not counted.
                    if (move_ready && !abort_hit) begin
                        cnt <= cnt + (IDX_W + 1)'(1);
                        if (!last_idx) begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!abort_hit) begin
                        move_count <= cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (from registered state and snapshot only)
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = (state != IDLE);
        move_valid = (state == EMIT);
        done       = (state == DONE);
        move_data  = '0;
        move_idx   = '0;
        if (state == EMIT) begin
            move_data = cur_word;
            move_idx  = idx;
        end
    end

endmodule

// File: tb/tb_move_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for move_collector.
//
// A transaction-level reference model lives in the negedge process: on an
// accepted start it builds a queue of the non-empty words (index, data) from
// the bus, and derives the expected cycle-by-cycle outputs from the timing
// rules (one cycle per examined word, plus one cycle per cycle a move is
// presented, then a single done cycle). Directed scenarios add literal
// expectations that pin the model; a randomized loop exercises random buses,
// random ready back-pressure, bus changes while busy and ignored restarts.
// -----------------------------------------------------------------------------
module tb_move_collector;

    localparam int NUM_DIR = 16;
    localparam int MOVE_W  = 32;
    localparam int IDX_W   = 4;

    typedef struct {
        int                idx;
        logic [MOVE_W-1:0] data;
    } item_t;

    logic                      clk = 1'b0;
    logic                      clear_n;
    logic                      start;
    logic [NUM_DIR*MOVE_W-1:0] move_bus;
    logic                      busy;
    logic                      move_valid;
    logic                      move_ready;
`ifdef MOVE_COLLECT_ABORT_EN
    logic                      abort;
`endif
    logic [MOVE_W-1:0]         move_data;
    logic [IDX_W-1:0]          move_idx;
    logic                      done;
    logic [IDX_W:0]            move_count;

    always #5 clk = ~clk;

    move_collector #(
        .NUM_DIR(NUM_DIR),
        .MOVE_W (MOVE_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .move_bus  (move_bus),
        .busy      (busy),
        .move_valid(move_valid),
        .move_ready(move_ready),
`ifdef MOVE_COLLECT_ABORT_EN
        .abort     (abort),
`endif
        .move_data (move_data),
        .move_idx  (move_idx),
        .done      (done),
        .move_count(move_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle counter and ready driver
    // ------------------------------------------------------------------
    int cyc = 0;
    int ready_mode = 0;   // 0 always 1, 1 toggle, 2 random, 3 held low, 4 manual

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: move_ready = 1'b1;
            1: move_ready = ~move_ready;
            2: move_ready = ($urandom_range(0, 3) != 0);
            3: move_ready = 1'b0;
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Reference model and per-cycle compare
    // ------------------------------------------------------------------
    bit     model_on = 0;
    bit     active   = 0;
    int     r        = 0;   // cycle number since the accepted start edge (1 = first)
    int     e_done   = 0;   // presentation cycles of moves already transferred
    int     stall    = 0;   // extra presentation cycles of the current move
    int     cnt_m    = 0;
    int     last_count = 0;
    item_t  q[$];

    int                xfer_idx[$];
    logic [MOVE_W-1:0] xfer_data[$];
    int                done_seen = 0;
    int                done_lat  = 0;
    int                start_edge = 0;

    always @(negedge clk) begin : cmp
        bit                exp_valid;
        bit                exp_done;
        bit                exp_busy;
        bit                ab;
        logic [MOVE_W-1:0] w;
        item_t             it;

        ab = 1'b0;
`ifdef MOVE_COLLECT_ABORT_EN
        ab = abort;
`endif
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
        if (model_on) begin
            if (active) begin
                exp_busy = 1'b1;
                if (q.size() > 0)
                    exp_valid = (r >= q[0].idx + 2 + e_done);
                else
                    exp_done = (r == NUM_DIR + 1 + e_done);
            end
            check("busy", busy, exp_busy);
            check("move_valid", move_valid, exp_valid);
            check("done", done, exp_done);
            check("move_count", move_count, last_count);
            if (exp_valid) begin
                check("move_data", move_data, q[0].data);
                check("move_idx", move_idx, q[0].idx);
            end
            if (done) begin
                done_seen++;
                done_lat = cyc - start_edge + 1;
            end
            if (move_valid && move_ready && clear_n && !ab) begin
                xfer_idx.push_back(int'(move_idx));
                xfer_data.push_back(move_data);
            end
        end

        // Advance the model across the coming rising edge.
        if (!clear_n) begin
            model_on   = 1;
            active     = 0;
            last_count = 0;
            q.delete();
        end else if (model_on) begin
            if (!active) begin
                if (start) begin
                    active = 1;
                    r      = 1;
                    e_done = 0;
                    stall  = 0;
                    cnt_m  = 0;
                    q.delete();
                    for (int i = 0; i < NUM_DIR; i++) begin
                        w = move_bus[i*MOVE_W +: MOVE_W];
                        if (w != '0) begin
                            it.idx  = i;
                            it.data = w;
                            q.push_back(it);
                        end
                    end
                    start_edge = cyc + 1;
                end
            end else if (ab) begin
                active = 0;
            end else if (exp_done) begin
                active     = 0;
                last_count = cnt_m;
            end else begin
                if (exp_valid) begin
                    if (move_ready) begin
                        void'(q.pop_front());
                        cnt_m++;
                        e_done += stall + 1;
                        stall = 0;
                    end else begin
                        stall++;
                    end
                end
                r++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xfer_idx.delete();
        xfer_data.delete();
        done_seen = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!move_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, "_valid_timeout"}, move_valid, 1'b1);
    endtask

    function automatic logic [NUM_DIR*MOVE_W-1:0] rand_bus();
        logic [NUM_DIR*MOVE_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_DIR; i++)
            if ($urandom_range(0, 1) != 0)
                b[i*MOVE_W +: MOVE_W] = $urandom;
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [NUM_DIR*MOVE_W-1:0] b;
        int                        nz;
        int                        n;

        clear_n    = 1'b0;
        start      = 1'b1;
        move_bus   = '0;
        move_ready = 1'b1;
`ifdef MOVE_COLLECT_ABORT_EN
        abort      = 1'b0;
`endif
        ready_mode = 0;

        // Reset with start held high: reset wins.
        repeat (2) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_valid", move_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_count", move_count, 0);
        check("reset_data", move_data, 0);
        check("reset_idx", move_idx, 0);
        clear_n = 1'b1;
        start   = 1'b0;
        tick();

        // All-empty bus.
        clear_logs();
        move_bus = '0;
        pulse_start();
        wait_idle("empty");
        check("empty_xfers", xfer_idx.size(), 0);
        check("empty_done_lat", done_lat, 17);
        check("empty_done_pulses", done_seen, 1);
        check("empty_count", move_count, 0);

        // Two sparse words; bus overwritten right after start.
        clear_logs();
        b = '0;
        b[1*MOVE_W +: MOVE_W] = 32'h0000_0294;
        b[9*MOVE_W +: MOVE_W] = 32'h0000_01AB;
        move_bus = b;
        pulse_start();
        move_bus = '1;
        wait_idle("sparse");
        check("sparse_xfers", xfer_idx.size(), 2);
        check("sparse_idx0", xfer_idx[0], 1);
        check("sparse_data0", xfer_data[0], 32'h0000_0294);
        check("sparse_idx1", xfer_idx[1], 9);
        check("sparse_data1", xfer_data[1], 32'h0000_01AB);
        check("sparse_done_lat", done_lat, 19);
        check("sparse_count", move_count, 2);

        // All 16 words present, ready toggling.
        clear_logs();
        for (int i = 0; i < NUM_DIR; i++)
            b[i*MOVE_W +: MOVE_W] = 32'h0000_0001 + 32'(i);
        move_bus   = b;
        ready_mode = 1;
        pulse_start();
        wait_idle("full");
        check("full_xfers", xfer_idx.size(), 16);
        for (int i = 0; i < NUM_DIR; i++) begin
            check("full_idx", xfer_idx[i], i);
            check("full_data", xfer_data[i], 32'h0000_0001 + 32'(i));
        end
        check("full_count", move_count, 16);

        // Second start while emitting is ignored.
        clear_logs();
        b = '0;
        b[3*MOVE_W +: MOVE_W]  = 32'h0000_000A;
        b[5*MOVE_W +: MOVE_W]  = 32'h0000_000B;
        b[12*MOVE_W +: MOVE_W] = 32'h0000_000C;
        move_bus = b;
        pulse_start();
        wait_valid("restart");
        pulse_start();
        wait_idle("restart");
        check("restart_xfers", xfer_idx.size(), 3);
        check("restart_idx0", xfer_idx[0], 3);
        check("restart_idx1", xfer_idx[1], 5);
        check("restart_idx2", xfer_idx[2], 12);
        check("restart_done_pulses", done_seen, 1);
        check("restart_count", move_count, 3);

        // Reset during a stalled EMIT.
        clear_logs();
        ready_mode = 3;
        pulse_start();
        wait_valid("rst_emit");
        repeat (2) tick();
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        check("rst_emit_busy", busy, 1'b0);
        check("rst_emit_valid", move_valid, 1'b0);
        check("rst_emit_done", done, 1'b0);
        check("rst_emit_count", move_count, 0);
        repeat (20) tick();
        check("rst_emit_no_done", done_seen, 0);

        // Randomized scans with back-pressure, bus noise and ignored starts.
        ready_mode = 2;
        for (int iter = 0; iter < 40; iter++) begin
            clear_logs();
            b  = rand_bus();
            nz = 0;
            for (int i = 0; i < NUM_DIR; i++)
                if (b[i*MOVE_W +: MOVE_W] != '0) nz++;
            move_bus = b;
            pulse_start();
            n = 0;
            while (busy && n < 3000) begin
                move_bus = rand_bus();
                start    = ($urandom_range(0, 7) == 0);
                tick();
                n++;
            end
            start = 1'b0;
            check("rand_timeout", busy, 1'b0);
            check("rand_count", move_count, nz);
            check("rand_xfers", xfer_idx.size(), nz);
            check("rand_done_pulses", done_seen, 1);
            tick();
        end

`ifdef MOVE_COLLECT_ABORT_EN
        // Reference scan, then abort while stalled on word 4 after 2 transfers.
        ready_mode = 0;
        clear_logs();
        b = '0;
        b[1*MOVE_W +: MOVE_W] = 32'h0000_0011;
        b[2*MOVE_W +: MOVE_W] = 32'h0000_0022;
        b[4*MOVE_W +: MOVE_W] = 32'h0000_0044;
        b[7*MOVE_W +: MOVE_W] = 32'h0000_0077;
        move_bus = b;
        pulse_start();
        wait_idle("abort_ref");
        check("abort_ref_count", move_count, 4);
        tick();

        clear_logs();
        ready_mode = 4;
        move_ready = 1'b1;
        pulse_start();
        n = 0;
        while (xfer_idx.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        check("abort_two_xfers", xfer_idx.size(), 2);
        move_ready = 1'b0;
        wait_valid("abort");
        check("abort_stall_idx", move_idx, 4);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", move_valid, 1'b0);
        repeat (5) tick();
        check("abort_no_done", done_seen, 0);
        check("abort_count_kept", move_count, 4);

        // abort and start together in IDLE: start wins.
        clear_logs();
        ready_mode = 0;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", busy, 1'b1);
        wait_idle("abort_after");
        check("abort_after_count", move_count, 4);
        check("abort_after_done", done_seen, 1);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
